// File: rtl/ip_ws2812_led_ctrl.sv
`timescale 1ns/1ps
// WS2812 frame sequencer: keeps one 24-bit colour per LED and feeds them to a single
// ip_ws2812_led in index order, then holds the line low for the latch gap.
// Optional feature macro WS2812_CTRL_AUTO_REFRESH_EN: accepted host writes also trigger frames.
module ip_ws2812_led_ctrl #(
    parameter int LED_COUNT    = 8,
    parameter int ADDR_WIDTH   = 3,
    parameter int LATCH_CYCLES = 12000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  host_wr,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [7:0]            host_red,
    input  logic [7:0]            host_green,
    input  logic [7:0]            host_blue,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  led_wr,
    input  logic                  led_sending,
    output logic [7:0]            led_red,
    output logic [7:0]            led_green,
    output logic [7:0]            led_blue
);

    localparam int                    CNT_W      = $clog2(LATCH_CYCLES + 1);
    localparam logic [ADDR_WIDTH:0]   LED_LIMIT  = (ADDR_WIDTH + 1)'(LED_COUNT);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(LED_COUNT - 1);
    localparam logic [CNT_W-1:0]      LATCH_LOAD = CNT_W'(LATCH_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ISSUE,
        ST_GUARD,
        ST_DRAIN,
        ST_LATCH
    } state_t;

    state_t                  state, state_nxt;
    logic [23:0]             entry [LED_COUNT];
    logic [ADDR_WIDTH-1:0]   index, index_nxt;
    logic [CNT_W-1:0]        latch_cnt, latch_cnt_nxt;
    logic                    guard, guard_nxt;
    logic                    pending, pending_nxt;
    logic                    done_nxt;
    logic                    wr_ok;
    logic                    kick;
    logic                    accept;

    assign wr_ok  = host_wr && ({1'b0, host_addr} < LED_LIMIT);
    assign accept = (state == ST_IDLE) && kick;

`ifdef WS2812_CTRL_AUTO_REFRESH_EN
    logic dirty;

    // A write landing in the accept cycle re-arms dirty, so one more frame follows.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dirty <= 1'b0;
        end else if (wr_ok) begin
            dirty <= 1'b1;
        end else if (accept) begin
            dirty <= 1'b0;
        end
    end

    assign kick = start || pending || dirty;
`else
    assign kick = start || pending;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LED_COUNT; i++) begin
                entry[i] <= '0;
            end
        end else if (wr_ok) begin
            entry[host_addr] <= {host_red, host_green, host_blue};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            index     <= '0;
            latch_cnt <= '0;
            guard     <= 1'b0;
            pending   <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            index     <= index_nxt;
            latch_cnt <= latch_cnt_nxt;
            guard     <= guard_nxt;
            pending   <= pending_nxt;
            done      <= done_nxt;
        end
    end

    // Any start outside the accept cycle is remembered; several merge into one frame.
    always_comb begin
        state_nxt     = state;
        index_nxt     = index;
        latch_cnt_nxt = latch_cnt;
        guard_nxt     = guard;
        pending_nxt   = pending || start;
        done_nxt      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    pending_nxt = 1'b0;
                    index_nxt   = '0;
                    state_nxt   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!led_sending) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                guard_nxt = 1'b0;
                state_nxt = ST_GUARD;
            end
            ST_GUARD: begin
                if (guard) begin
                    if (index == LAST_IDX) begin
                        state_nxt = ST_DRAIN;
                    end else begin
                        index_nxt = index + ADDR_WIDTH'(1);
                        state_nxt = ST_WAIT;
                    end
                end else begin
                    guard_nxt = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (!led_sending) begin
                    latch_cnt_nxt = LATCH_LOAD;
                    state_nxt     = ST_LATCH;
                end
            end
            ST_LATCH: begin
                if (latch_cnt == '0) begin
                    done_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    latch_cnt_nxt = latch_cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy   = (state != ST_IDLE);
    assign led_wr = (state == ST_ISSUE);
    assign {led_red, led_green, led_blue} = led_wr ? entry[index] : 24'd0;

endmodule
